// File: rtl/window_level_counter_pkg.sv
// window_level_counter_pkg: shared constants and width helper for the windowed level counter.
//   MODE_LEVEL / MODE_EDGE select level or edge counting; pos_w() sizes the window position counter.
package window_level_counter_pkg;
    localparam int MODE_LEVEL = 0;
    localparam int MODE_EDGE  = 1;
    function automatic int pos_w(input int win);
        return (win <= 2) ? 1 : $clog2(win);
    endfunction
endpackage

// File: rtl/window_level_chan.sv
// window_level_chan: one channel of hit detection, saturating accumulator, count and peak.
//   clk, rst     : clock, synchronous active-high reset
//   en, clr      : sample strobe, soft clear of accumulator/peak/edge history
//   close        : this en cycle ends the window (shared from the top)
//   rx           : channel input bit
//   count, peak  : last completed window count and running maximum
module window_level_chan
    import window_level_counter_pkg::*;
#(
    parameter int   W         = 4,
    parameter logic BIT_VALUE = 1'b0,
    parameter int   MODE      = MODE_LEVEL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         close,
    input  logic         rx,
    output logic [W-1:0] count,
    output logic [W-1:0] peak
);
    logic [W-1:0] acc_q, acc_d, count_q, peak_q;
    logic         prev_q, hit;
    assign hit   = en && (rx == BIT_VALUE) && (MODE == MODE_LEVEL || prev_q != BIT_VALUE);
    // Holds at all-ones so a busy window reports the maximum instead of wrapping.
    assign acc_d = (&acc_q) ? acc_q : acc_q + W'(hit);
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
            peak_q  <= '0;
            prev_q  <= BIT_VALUE;
        end else if (clr) begin
            acc_q  <= '0;
            peak_q <= '0;
            prev_q <= BIT_VALUE;
        end else if (en) begin
            prev_q <= rx;
            if (close) begin
                count_q <= acc_d;
                peak_q  <= (acc_d > peak_q) ? acc_d : peak_q;
                acc_q   <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end
    assign count = count_q;
    assign peak  = peak_q;
endmodule

// File: rtl/window_level_counter.sv
// window_level_counter: per-channel windowed count of BIT_VALUE samples (or edges) with running peak.
//   clk, rst : clock, synchronous active-high reset
//   en       : sample strobe, advances the window
//   clr      : soft clear of window and peaks (count held)
//   rx       : CH input bits
//   count    : last window counts, channel i at [i*W +: W]
//   peak     : maximum window count since rst/clr, same packing
//   valid    : one-cycle pulse when count/peak have just updated
module window_level_counter
    import window_level_counter_pkg::*;
#(
    parameter int   CH        = 2,
    parameter int   W         = 4,
    parameter int   WIN       = 8,
    parameter logic BIT_VALUE = 1'b0,
    parameter int   MODE      = MODE_LEVEL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [CH-1:0]   rx,
    output logic [CH*W-1:0] count,
    output logic [CH*W-1:0] peak,
    output logic            valid
);
    localparam int PW = pos_w(WIN);
    logic [PW-1:0] pos_q, pos_d;
    logic          valid_q, close;
    assign close = en && (pos_q == PW'(WIN - 1));
    assign pos_d = close ? '0 : pos_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pos_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= close;
            if (en) pos_q <= pos_d;
        end
    end
    assign valid = valid_q;
    for (genvar i = 0; i < CH; i++) begin : g_ch
        window_level_chan #(.W(W), .BIT_VALUE(BIT_VALUE), .MODE(MODE)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .clr  (clr),
            .close(close),
            .rx   (rx[i]),
            .count(count[i*W +: W]),
            .peak (peak[i*W +: W])
        );
    end
endmodule
